// File: rtl/burst_arb_pkg.sv
// Shared types and constants for the Cellular RAM burst arbiter.
package burst_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } ArbState;

    localparam int ADDR_WIDTH = 20;
    localparam int DATA_WIDTH = 16;

    // 150 us power-up hold-off at 100 MHz, and the Done watchdog length
    localparam int DEFAULT_INIT_CYCLES    = 15000;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Used to size the shared timer so it can hold either load value
    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_arb_timer.sv
// Loadable down-counter shared by the power-up wait and the transfer watchdog.
// terminal is high during the last counted cycle (count == 1) and stays high
// once the counter has run out, so a load of N gives exactly N cycles.
module burst_arb_timer #(
    parameter int              WIDTH       = 14,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Reset reloads the power-up interval; otherwise load or count down to zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count <= WIDTH'(1));

endmodule

// File: rtl/burst_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the Cellular RAM
// burst engine. Holds off traffic until power-up completes, latches the
// winner's address/data, drives CE, routes Yield/Done back to the owner and
// aborts transfers whose Done never arrives.
module burst_arbiter
    import burst_arb_pkg::*;
#(
    parameter int INIT_CYCLES    = DEFAULT_INIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] Data0,
    input  logic [DATA_WIDTH-1:0] Data1,
    output logic                  Grant0,
    output logic                  Grant1,
    output logic                  Yield0,
    output logic                  Yield1,
    output logic                  Done0,
    output logic                  Done1,
    output logic [ADDR_WIDTH-1:0] EngAddress,
    output logic [DATA_WIDTH-1:0] EngData,
    output logic                  EngCE,
    input  logic                  EngYield,
    input  logic                  EngDone,
    output logic                  Ready,
    output logic                  TimeoutErr
);

    localparam int TIMER_WIDTH = $clog2(maxOf(INIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [TIMER_WIDTH-1:0] INIT_LOAD    = TIMER_WIDTH'(INIT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES);

    ArbState               state;
    ArbState               stateNext;
    logic [1:0]            grantQ;
    logic [1:0]            grantNext;
    logic [1:0]            doneQ;
    logic [1:0]            doneNext;
    logic                  engCeQ;
    logic                  engCeNext;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [ADDR_WIDTH-1:0] addrNext;
    logic [DATA_WIDTH-1:0] dataQ;
    logic [DATA_WIDTH-1:0] dataNext;
    logic                  readyQ;
    logic                  readyNext;
    logic                  timeoutQ;
    logic                  timeoutNext;
    logic                  lastServed;
    logic                  lastServedNext;
    logic                  winner;
    logic                  timerLoad;
    logic                  timerTerminal;

    // One counter covers both the power-up wait and the per-transfer watchdog
    burst_arb_timer #(
        .WIDTH       (TIMER_WIDTH),
        .RESET_VALUE (INIT_LOAD)
    ) timer (
        .clock     (CLK),
        .reset     (Reset),
        .load      (timerLoad),
        .loadValue (TIMEOUT_LOAD),
        .terminal  (timerTerminal)
    );

    // State and all registered outputs; last-served starts at port 1 so port 0 wins the first tie
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= INIT;
            grantQ     <= 2'b00;
            doneQ      <= 2'b00;
            engCeQ     <= 1'b0;
            addrQ      <= '0;
            dataQ      <= '0;
            readyQ     <= 1'b0;
            timeoutQ   <= 1'b0;
            lastServed <= 1'b1;
        end else begin
            state      <= stateNext;
            grantQ     <= grantNext;
            doneQ      <= doneNext;
            engCeQ     <= engCeNext;
            addrQ      <= addrNext;
            dataQ      <= dataNext;
            readyQ     <= readyNext;
            timeoutQ   <= timeoutNext;
            lastServed <= lastServedNext;
        end
    end

    // Next-state logic: arbitrate in IDLE, watch for Done or timeout in BUSY, force a CE gap in RELEASE
    always_comb begin
        stateNext      = state;
        grantNext      = grantQ;
        doneNext       = 2'b00;
        engCeNext      = engCeQ;
        addrNext       = addrQ;
        dataNext       = dataQ;
        readyNext      = readyQ;
        timeoutNext    = timeoutQ;
        lastServedNext = lastServed;
        winner         = 1'b0;
        timerLoad      = 1'b0;

        case (state)
            INIT: begin
                if (timerTerminal) begin
                    stateNext = IDLE;
                    readyNext = 1'b1;
                end
            end

            IDLE: begin
                if (Req0 || Req1) begin
                    if (Req0 && Req1) begin
                        winner = ~lastServed;
                    end else begin
                        winner = Req1;
                    end
                    grantNext = winner ? 2'b10 : 2'b01;
                    addrNext  = winner ? Addr1 : Addr0;
                    dataNext  = winner ? Data1 : Data0;
                    engCeNext = 1'b1;
                    timerLoad = 1'b1;
                    stateNext = BUSY;
                end
            end

            BUSY: begin
                if (EngDone || timerTerminal) begin
                    engCeNext      = 1'b0;
                    doneNext       = grantQ;
                    lastServedNext = grantQ[1];
                    stateNext      = RELEASE;
                    if (!EngDone) begin
                        timeoutNext = 1'b1;
                    end
                end
            end

            RELEASE: begin
                grantNext = 2'b00;
                stateNext = IDLE;
            end

            default: begin
                stateNext = INIT;
            end
        endcase
    end

    assign Grant0     = grantQ[0];
    assign Grant1     = grantQ[1];
    assign Done0      = doneQ[0];
    assign Done1      = doneQ[1];
    assign Yield0     = grantQ[0] & EngYield;
    assign Yield1     = grantQ[1] & EngYield;
    assign EngCE      = engCeQ;
    assign EngAddress = addrQ;
    assign EngData    = dataQ;
    assign Ready      = readyQ;
    assign TimeoutErr = timeoutQ;

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed testbench for burst_arbiter with INIT_CYCLES=8, TIMEOUT_CYCLES=6.
module tb_burst_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Req0, Req1;
    logic [19:0] Addr0, Addr1;
    logic [15:0] Data0, Data1;
    logic        Grant0, Grant1, Yield0, Yield1, Done0, Done1;
    logic [19:0] EngAddress;
    logic [15:0] EngData;
    logic        EngCE, EngYield, EngDone, Ready, TimeoutErr;

    int vectors = 0;
    int miscompares = 0;

    burst_arbiter #(
        .INIT_CYCLES    (8),
        .TIMEOUT_CYCLES (6)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Req0       (Req0),
        .Req1       (Req1),
        .Addr0      (Addr0),
        .Addr1      (Addr1),
        .Data0      (Data0),
        .Data1      (Data1),
        .Grant0     (Grant0),
        .Grant1     (Grant1),
        .Yield0     (Yield0),
        .Yield1     (Yield1),
        .Done0      (Done0),
        .Done1      (Done1),
        .EngAddress (EngAddress),
        .EngData    (EngData),
        .EngCE      (EngCE),
        .EngYield   (EngYield),
        .EngDone    (EngDone),
        .Ready      (Ready),
        .TimeoutErr (TimeoutErr)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Req0 = 0; Req1 = 0; EngYield = 0; EngDone = 0;
        Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;
        tick();
        tick();
        vectors++;
        if ({Grant0, Grant1, Yield0, Yield1, Done0, Done1, EngCE, Ready, TimeoutErr, EngAddress, EngData} !== 45'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {Grant0, Grant1, Yield0, Yield1, Done0, Done1, EngCE, Ready, TimeoutErr, EngAddress, EngData});
        end
    endtask

    task automatic test_power_up();
        Req0 = 1'b1; Addr0 = 20'hAAAAA; Data0 = 16'h5555;
        Reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            vectors++;
            if ({Ready, Grant0} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL powerup_hold cycle %0d: got %b expected 00", i, {Ready, Grant0});
            end
        end
        tick();
        vectors++;
        if ({Ready, Grant0} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL powerup_ready: got %b expected 10", {Ready, Grant0});
        end
        tick();
        vectors++;
        if ({Grant0, Grant1, EngCE, EngAddress, EngData} !== {3'b101, 20'hAAAAA, 16'h5555}) begin
            miscompares++;
            $display("[TB] FAIL powerup_grant: got %h expected %h",
                     {Grant0, Grant1, EngCE, EngAddress, EngData}, {3'b101, 20'hAAAAA, 16'h5555});
        end
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0; Req0 = 1'b0;
        vectors++;
        if ({Done0, EngCE, Grant0} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL powerup_done: got %b expected 101", {Done0, EngCE, Grant0});
        end
        tick();
    endtask

    task automatic test_single_write();
        Req0 = 1'b1; Addr0 = 20'h12345; Data0 = 16'hBEEF;
        tick();
        vectors++;
        if ({Grant0, EngCE, EngAddress, EngData} !== {2'b11, 20'h12345, 16'hBEEF}) begin
            miscompares++;
            $display("[TB] FAIL write_grant: got %h expected %h",
                     {Grant0, EngCE, EngAddress, EngData}, {2'b11, 20'h12345, 16'hBEEF});
        end
        Addr0 = 20'hFFFFF; Data0 = 16'h0000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if ({EngCE, Done0, EngAddress, EngData} !== {2'b10, 20'h12345, 16'hBEEF}) begin
                miscompares++;
                $display("[TB] FAIL write_hold cycle %0d: got %h expected %h", i,
                         {EngCE, Done0, EngAddress, EngData}, {2'b10, 20'h12345, 16'hBEEF});
            end
        end
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0; Req0 = 1'b0;
        vectors++;
        if ({Done0, EngCE, Grant0} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL write_done: got %b expected 101", {Done0, EngCE, Grant0});
        end
        tick();
        vectors++;
        if ({Done0, EngCE, Grant0} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL write_release: got %b expected 000", {Done0, EngCE, Grant0});
        end
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0;
        vectors++;
        if ({Done0, Done1, Grant0, Grant1, EngCE} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL stray_done_idle: got %b expected 00000", {Done0, Done1, Grant0, Grant1, EngCE});
        end
    endtask

    task automatic test_yield();
        Req1 = 1'b1; Addr1 = 20'h0BEEF; Data1 = 16'h1234;
        tick();
        vectors++;
        if ({Grant0, Grant1, EngCE, EngAddress, EngData} !== {3'b011, 20'h0BEEF, 16'h1234}) begin
            miscompares++;
            $display("[TB] FAIL yield_grant1: got %h expected %h",
                     {Grant0, Grant1, EngCE, EngAddress, EngData}, {3'b011, 20'h0BEEF, 16'h1234});
        end
        EngYield = 1'b1;
        #1;
        vectors++;
        if ({Yield0, Yield1} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL yield_high: got %b expected 01", {Yield0, Yield1});
        end
        EngYield = 1'b0;
        #1;
        vectors++;
        if ({Yield0, Yield1} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL yield_low: got %b expected 00", {Yield0, Yield1});
        end
        EngYield = 1'b1;
        tick();
        vectors++;
        if ({Yield0, Yield1} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL yield_after_edge: got %b expected 01", {Yield0, Yield1});
        end
        EngYield = 1'b0; EngDone = 1'b1;
        tick();
        EngDone = 1'b0; Req1 = 1'b0;
        vectors++;
        if ({Done0, Done1} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL yield_done1: got %b expected 01", {Done0, Done1});
        end
        tick();
        EngYield = 1'b1;
        #1;
        vectors++;
        if ({Grant1, Yield0, Yield1} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL yield_ungranted: got %b expected 000", {Grant1, Yield0, Yield1});
        end
        EngYield = 1'b0;
    endtask

    task automatic test_contention();
        logic       expPort;
        logic [19:0] expAddr;
        Req0 = 1'b1; Req1 = 1'b1;
        Addr0 = 20'h00A00; Addr1 = 20'h00B01; Data0 = 16'h000A; Data1 = 16'h000B;
        for (int k = 0; k < 4; k++) begin
            expPort = (k % 2) == 1;
            expAddr = expPort ? 20'h00B01 : 20'h00A00;
            tick();
            vectors++;
            if ({Grant0, Grant1, EngCE, EngAddress} !== {~expPort, expPort, 1'b1, expAddr}) begin
                miscompares++;
                $display("[TB] FAIL contention_grant %0d: got %h expected %h", k,
                         {Grant0, Grant1, EngCE, EngAddress}, {~expPort, expPort, 1'b1, expAddr});
            end
            EngDone = 1'b1;
            tick();
            EngDone = 1'b0;
            vectors++;
            if ({Done0, Done1, EngCE} !== {~expPort, expPort, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL contention_done %0d: got %b expected %b", k,
                         {Done0, Done1, EngCE}, {~expPort, expPort, 1'b0});
            end
            tick();
            vectors++;
            if ({Grant0, Grant1, EngCE} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL contention_gap %0d: got %b expected 000", k, {Grant0, Grant1, EngCE});
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic test_done_vs_timeout();
        Req1 = 1'b1; Addr1 = 20'h00777;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
        end
        vectors++;
        if ({EngCE, Done1} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL race_busy: got %b expected 10", {EngCE, Done1});
        end
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0; Req1 = 1'b0;
        vectors++;
        if ({Done1, EngCE, TimeoutErr} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL race_done_priority: got %b expected 100", {Done1, EngCE, TimeoutErr});
        end
        tick();
        vectors++;
        if ({Grant1, TimeoutErr} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL race_release: got %b expected 00", {Grant1, TimeoutErr});
        end
    endtask

    task automatic test_timeout();
        Req0 = 1'b1; Addr0 = 20'h00100;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if ({EngCE, Done0, TimeoutErr} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL timeout_busy cycle %0d: got %b expected 100", i, {EngCE, Done0, TimeoutErr});
            end
        end
        tick();
        Req0 = 1'b0;
        vectors++;
        if ({EngCE, Done0, TimeoutErr} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL timeout_abort: got %b expected 011", {EngCE, Done0, TimeoutErr});
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if ({Grant0, Done0, TimeoutErr} !== 3'b001) begin
                miscompares++;
                $display("[TB] FAIL timeout_sticky %0d: got %b expected 001", i, {Grant0, Done0, TimeoutErr});
            end
        end
    endtask

    task automatic test_mid_reset();
        Req0 = 1'b1; Addr0 = 20'h54321; Data0 = 16'hCAFE;
        tick();
        tick();
        vectors++;
        if ({Grant0, EngCE} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL midreset_busy: got %b expected 11", {Grant0, EngCE});
        end
        Reset = 1'b1; EngDone = 1'b1;
        tick();
        vectors++;
        if ({Grant0, Grant1, Yield0, Yield1, Done0, Done1, EngCE, Ready, TimeoutErr, EngAddress, EngData} !== 45'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0",
                     {Grant0, Grant1, Yield0, Yield1, Done0, Done1, EngCE, Ready, TimeoutErr, EngAddress, EngData});
        end
        Reset = 1'b0; EngDone = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            vectors++;
            if ({Ready, Grant0, Done0} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL midreset_hold cycle %0d: got %b expected 000", i, {Ready, Grant0, Done0});
            end
        end
        tick();
        vectors++;
        if ({Ready, Grant0} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL midreset_ready: got %b expected 10", {Ready, Grant0});
        end
        tick();
        vectors++;
        if ({Grant0, EngCE, EngAddress} !== {2'b11, 20'h54321}) begin
            miscompares++;
            $display("[TB] FAIL midreset_regrant: got %h expected %h", {Grant0, EngCE, EngAddress}, {2'b11, 20'h54321});
        end
        EngDone = 1'b1;
        tick();
        EngDone = 1'b0; Req0 = 1'b0;
        tick();
    endtask

    // Directed scenario sequence; each test leaves the arbiter idle for the next
    initial begin
        test_reset();
        test_power_up();
        test_single_write();
        test_yield();
        test_contention();
        test_done_vs_timeout();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
